// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, IV, FSM encoding and round helper functions
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] e0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] e1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic logic [31:0] wd(input logic [511:0] v, input int i);
    return v[32*i +: 32];
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round plus one message-schedule step
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st,
  input  logic [31:0]  k,
  input  logic [511:0] w,
  output logic [255:0] st_n,
  output logic [511:0] w_n
);
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
  always_comb begin
    {h, g, f, e, d, c, b, a} = st;
    t1 = h + e1(e) + ch(e, f, g) + k + wd(w, 0);
    t2 = e0(a) + maj(a, b, c);
    st_n = {g, f, e, d + t1, c, b, a, t1 + t2};
    w_n = {s1(wd(w, 14)) + wd(w, 9) + s0(wd(w, 1)) + wd(w, 0), w[511:32]};
  end
endmodule

// File: rtl/sha256_core_iter.sv
// sha256_core_iter: iterative chained SHA-256 compressor, UNROLL rounds/clock; SHA256_MIDSTATE_EN adds midstate seeding
module sha256_core_iter
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
`ifdef SHA256_MIDSTATE_EN
  ,
  input  logic [255:0] in_midstate,
  input  logic         in_use_mid
`endif
);
  localparam logic [5:0] STEP = 6'(UNROLL);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad
    $error("UNROLL must be 1, 2, 4 or 8");
  end
  fsm_t fsm;
  logic [5:0] cnt, cnt_n;
  logic [255:0] st, base, chain, seed, sum;
  logic [511:0] win;
  logic [255:0] st_c [UNROLL+1];
  logic [511:0] w_c [UNROLL+1];
  assign st_c[0] = st;
  assign w_c[0] = win;
  assign cnt_n = cnt + STEP;
`ifdef SHA256_MIDSTATE_EN
  assign seed = in_use_mid ? in_midstate : in_first ? IV : chain;
`else
  assign seed = in_first ? IV : chain;
`endif
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    sha256_round u_rnd (
      .st  (st_c[j]),
      .k   (K[cnt + 6'(j)]),
      .w   (w_c[j]),
      .st_n(st_c[j+1]),
      .w_n (w_c[j+1])
    );
  end
  for (genvar i = 0; i < 8; i++) begin : g_sum
    assign sum[32*i +: 32] = base[32*i +: 32] + st[32*i +: 32];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      out_digest <= '0;
      chain <= IV;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          st <= seed;
          base <= seed;
          win <= in_block;
          cnt <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          fsm <= ROUND;
        end
        ROUND: begin
          st <= st_c[UNROLL];
          win <= w_c[UNROLL];
          cnt <= cnt_n;
          fsm <= (cnt_n == '0) ? FINAL : ROUND;
        end
        FINAL: begin
          out_digest <= sum;
          chain <= sum;
          out_valid <= 1'b1;
          busy <= 1'b0;
          fsm <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_core_iter.sv
// tb_sha256_core_iter: scoreboard bench for UNROLL 1/2/4/8 against a from-first-principles SHA-256 model
module tb_sha256_core_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  logic [31:0] kk [64];
  logic [255:0] iv;

  function automatic void chk(string nm, int u, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s U=%0d got=%h want=%h", nm, u, act, exp);
    end
  endfunction
  function automatic void chkb(string nm, int u, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s U=%0d got=%b want=%b", nm, u, act, exp);
    end
  endfunction
  function automatic void chkn(string nm, int u, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s U=%0d got=%0d want=%0d", nm, u, act, exp);
    end
  endfunction
  function automatic void bad(string nm, int u);
    checks++;
    failures++;
    $display("FAIL %s U=%0d got=no-event want=event-within-bound", nm, u);
  endfunction

  function automatic logic [31:0] frac32(real r);
    real f;
    f = r - $floor(r);
    return 32'(longint'($floor(f * 4294967296.0)));
  endfunction
  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(logic [255:0] h, logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int j = 0; j < 8; j++) v[j] = h[32*j +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[32*j +: 32] = h[32*j +: 32] + v[j];
    return r;
  endfunction
  function automatic logic [255:0] dg(logic [255:0] be);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = be[32*(7-j) +: 32];
    return r;
  endfunction
  function automatic logic [511:0] abc();
    logic [511:0] b;
    b = '0;
    b[31:0] = 32'h61626380;
    b[511:480] = 32'h18;
    return b;
  endfunction
  function automatic logic [511:0] empty();
    logic [511:0] b;
    b = '0;
    b[31:0] = 32'h80000000;
    return b;
  endfunction
  function automatic logic [511:0] nopq(bit second);
    logic [511:0] b;
    b = '0;
    if (second) b[511:480] = 32'h1c0;
    else begin
      for (int i = 0; i < 14; i++) b[32*i +: 32] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
      b[479:448] = 32'h80000000;
    end
    return b;
  endfunction

  localparam logic [255:0] ABC_D = dg(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
  localparam logic [255:0] EMPTY_D = dg(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
  localparam logic [255:0] TWO_D = dg(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

  for (genvar i = 0; i < 4; i++) begin : g
    localparam int U = 1 << i;
    logic rst_n = 1'b0, in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b0, hold = 1'b0, done = 1'b0;
    logic in_ready, out_valid, busy;
    logic [511:0] in_block = '0;
    logic [255:0] out_digest, chain;
    logic [255:0] exp_q [$];
`ifdef SHA256_MIDSTATE_EN
    logic [255:0] in_midstate = '0;
    logic in_use_mid = 1'b0;
`endif
    sha256_core_iter #(.UNROLL(U)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
      .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest), .busy(busy)
`ifdef SHA256_MIDSTATE_EN
      , .in_midstate(in_midstate), .in_use_mid(in_use_mid)
`endif
    );

    task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      chain = iv;
      chkb("rst_in_ready", U, in_ready, 1'b1);
      chkb("rst_out_valid", U, out_valid, 1'b0);
      chkb("rst_busy", U, busy, 1'b0);
      chk("rst_digest", U, out_digest, '0);
    endtask
    task automatic xfer(logic f, logic [511:0] b, logic [255:0] want = '0);
      logic [255:0] m;
      int n;
      n = 0;
      m = compress(f ? iv : chain, b);
`ifdef SHA256_MIDSTATE_EN
      if (in_use_mid) m = compress(in_midstate, b);
`endif
      chain = m;
      in_valid = 1'b1;
      in_first = f;
      in_block = b;
      while (!in_ready) begin
        if (++n > 3000) begin
          bad("accept_timeout", U);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      exp_q.push_back(want != '0 ? want : m);
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask
    task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 5000) begin @(posedge clk); #1; n++; end
      if (n >= 5000) bad("drain_timeout", U);
    endtask

    initial forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    initial begin
      logic [511:0] b;
      int n;
      do_reset();
      xfer(1'b1, abc(), ABC_D);
      xfer(1'b1, empty(), EMPTY_D);
      xfer(1'b1, nopq(1'b0));
      xfer(1'b0, nopq(1'b1), TWO_D);
      drain();
      hold = 1'b1;
      xfer(1'b1, abc(), ABC_D);
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 20; c++) begin
        for (int j = 0; j < 16; j++) in_block[32*j +: 32] = $urandom();
        in_valid = c[0];
        in_first = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      hold = 1'b0;
      drain();
      xfer(1'b1, abc(), ABC_D);
      xfer(1'b1, nopq(1'b0));
      drain();
      xfer(1'b0, nopq(1'b1), TWO_D);
      repeat (30 / U) begin @(posedge clk); #1; end
      void'(exp_q.pop_back());
      do_reset();
      xfer(1'b0, nopq(1'b1));
      drain();
      for (int r = 0; r < 12; r++) begin
        for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom();
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        xfer($urandom_range(0, 3) == 0, b);
      end
`ifdef SHA256_MIDSTATE_EN
      drain();
      in_midstate = compress(iv, nopq(1'b0));
      in_use_mid = 1'b1;
      xfer(1'b1, nopq(1'b1), TWO_D);
      in_use_mid = 1'b0;
      xfer(1'b0, abc());
`endif
      drain();
      done = 1'b1;
    end

    initial begin
      logic [255:0] cur;
      logic pv, hs, inf;
      int acc [$];
      cur = '0;
      pv = 1'b0;
      hs = 1'b0;
      inf = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          acc.delete();
          pv = 1'b0;
          hs = 1'b0;
          inf = 1'b0;
        end else begin
          if (hs) chkb("valid_drop", U, out_valid, 1'b0);
          if (out_valid && !pv) begin
            inf = 1'b0;
            if (exp_q.size() == 0) bad("unexpected_digest", U);
            else begin
              cur = exp_q.pop_front();
              chk("digest", U, out_digest, cur);
              if (acc.size() != 0) chkn("latency", U, cyc - acc.pop_front(), 64 / U + 1);
              else bad("accept_before_digest", U);
            end
          end else if (out_valid) chk("digest_hold", U, out_digest, cur);
          chkb("busy", U, busy, inf);
          chkb("in_ready", U, in_ready, !out_valid && !inf);
          if (in_valid && in_ready) begin
            acc.push_back(cyc + 1);
            inf = 1'b1;
          end
          pv = out_valid;
          hs = out_valid && out_ready;
        end
      end
    end
  end

  initial begin
    int p, n, t;
    bit pr;
    p = 2;
    n = 0;
    while (n < 64) begin
      pr = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) pr = 1'b0;
      if (pr) begin
        kk[n] = frac32(real'(p) ** (1.0 / 3.0));
        if (n < 8) iv[32*n +: 32] = frac32($sqrt(real'(p)));
        n++;
      end
      p++;
    end
    t = 0;
    while (!(g[0].done && g[1].done && g[2].done && g[3].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60000) bad("global_timeout", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
